// File: rtl/c499_lock_ctrl.sv
// c499_lock_ctrl
// Sequencing controller for the key-locked c499 SEC core. It shifts in the
// unlock key serially, then passes one data word at a time through the
// combinational core. Each word is given LAT cycles to settle, and the
// corrected result is returned over a valid/ready handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_load            start/restart a serial key load
//   key_sval, key_sin   serial key bit strobe and data, LSB first
//   key, key_ready      committed key to the core, key committed flag
//   in_valid/in_ready   input word handshake, in_data word
//   core_in, core_out   registered word into the core, combinational result
//   out_valid/out_ready result handshake, out_data registered result
//   err_unkeyed         sticky: input offered while no key was committed
module c499_lock_ctrl #(
    parameter int KEY_W = 37,
    parameter int IN_W  = 41,
    parameter int OUT_W = 32,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic             key_sval,
    input  logic             key_sin,
    output logic [KEY_W-1:0] key,
    output logic             key_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic [IN_W-1:0]  core_in,
    input  logic [OUT_W-1:0] core_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             err_unkeyed
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
    localparam logic [3:0] LAT_INIT = 4'(LAT);

    typedef enum logic [2:0] {
        S_UNKEYED,
        S_LOAD,
        S_KEYED,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state, state_nx;
    logic [KEY_W-1:0] shadow, shadow_nx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       wcnt;
    logic             committed;   // a key has been committed since reset

    logic load_start, shift_en, commit, accept, tick, capture, release_o, set_err;

    always_comb begin
        state_nx   = state;
        load_start = 1'b0;
        shift_en   = 1'b0;
        commit     = 1'b0;
        accept     = 1'b0;
        tick       = 1'b0;
        capture    = 1'b0;
        release_o  = 1'b0;
        set_err    = 1'b0;
        // The committing edge must see the bit being shifted this cycle.
        shadow_nx      = shadow;
        shadow_nx[cnt] = key_sin;

        case (state)
            S_UNKEYED: begin
                set_err = in_valid;
                if (key_load) begin
                    state_nx   = S_LOAD;
                    load_start = 1'b1;
                end
            end
            S_LOAD: begin
                set_err = in_valid & ~committed;
                if (key_load) begin
                    // Restart: the strobe in this cycle is dropped.
                    load_start = 1'b1;
                end else if (key_sval) begin
                    shift_en = 1'b1;
                    if (cnt == LAST_BIT) begin
                        commit   = 1'b1;
                        state_nx = S_KEYED;
                    end
                end
            end
            S_KEYED: begin
                // A reload wins over a pending word.
                if (key_load) begin
                    state_nx   = S_LOAD;
                    load_start = 1'b1;
                end else if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt <= 4'd1) begin
                    capture  = 1'b1;
                    state_nx = S_HOLD;
                end else begin
                    tick = 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    release_o = 1'b1;
                    state_nx  = S_KEYED;
                end
            end
            default: state_nx = S_UNKEYED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_UNKEYED;
            shadow      <= '0;
            cnt         <= '0;
            wcnt        <= '0;
            committed   <= 1'b0;
            key         <= '0;
            key_ready   <= 1'b0;
            in_ready    <= 1'b0;
            core_in     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_unkeyed <= 1'b0;
        end else begin
            state <= state_nx;

            if (load_start) begin
                cnt    <= '0;
                shadow <= '0;
            end else if (shift_en) begin
                cnt    <= cnt + 1'b1;
                shadow <= shadow_nx;
            end

            if (commit) begin
                key       <= shadow_nx;
                committed <= 1'b1;
            end

            // Both flags are decoded from the next state so they are plain
            // flops with no path from in_valid/out_ready to the outputs.
            key_ready <= (state_nx == S_KEYED) || (state_nx == S_WAIT) ||
                         (state_nx == S_HOLD);
            in_ready  <= (state_nx == S_KEYED);

            if (accept) begin
                core_in <= in_data;
                wcnt    <= LAT_INIT;
            end else if (tick) begin
                wcnt <= wcnt - 4'd1;
            end

            if (capture) begin
                out_data  <= core_out;
                out_valid <= 1'b1;
            end else if (release_o) begin
                out_valid <= 1'b0;
            end

            if (set_err) begin
                err_unkeyed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_c499_lock_ctrl.sv
// Bench for c499_lock_ctrl: two instances (LAT=1 and LAT=4) share the stimulus.
// Each instance has a stand-in core and its own scoreboard queue, and one
// negedge monitor checks both result streams.
module tb_c499_lock_ctrl;
    localparam int KW = 37;
    localparam int IW = 41;
    localparam int OW = 32;

    typedef struct {
        logic [OW-1:0] data;
        int            acc;   // edge index at which the word is accepted
    } exp_t;

    logic clk = 1'b0;
    logic rst, key_load, key_sval, key_sin, in_valid, out_ready;
    logic [IW-1:0] in_data;
    logic [KW-1:0] key [2];
    logic          kr  [2];
    logic          ir  [2];
    logic          ov  [2];
    logic          err [2];
    logic [IW-1:0] cin [2];
    logic [OW-1:0] cout[2];
    logic [OW-1:0] od  [2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [KW-1:0] cur_key = '0;
    exp_t sb[2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the locked core: any fixed function of the word will do.
    function automatic logic [OW-1:0] core_fn(input logic [IW-1:0] w);
        return w[31:0] ^ 32'hFFFF_FFFF ^ {23'h0, w[40:32]};
    endfunction

    assign cout[0] = core_fn(cin[0]);
    assign cout[1] = core_fn(cin[1]);

    c499_lock_ctrl #(.LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .key_load(key_load), .key_sval(key_sval),
        .key_sin(key_sin), .key(key[0]), .key_ready(kr[0]),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .core_in(cin[0]), .core_out(cout[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .err_unkeyed(err[0])
    );

    c499_lock_ctrl #(.LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .key_load(key_load), .key_sval(key_sval),
        .key_sin(key_sin), .key(key[1]), .key_ready(kr[1]),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .core_in(cin[1]), .core_out(cout[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .err_unkeyed(err[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // ---------------- monitor ----------------
    logic          pov[2] = '{1'b0, 1'b0};
    logic          phs[2] = '{1'b0, 1'b0};
    logic [OW-1:0] pod[2];
    int            xfers[2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                sb[i].delete();
                pov[i] = 1'b0;
                phs[i] = 1'b0;
            end else begin
                if (sb[i].size() > 0 && sb[i][0].acc <= cyc)
                    chk($sformatf("d%0d in_ready busy", i), ir[i], 0);
                if (pov[i] && !phs[i]) begin
                    chk($sformatf("d%0d out_valid held", i), ov[i], 1);
                    chk($sformatf("d%0d out_data stable", i), od[i], pod[i]);
                end
                if (ov[i] && !pov[i]) begin
                    if (sb[i].size() == 0)
                        chk($sformatf("d%0d spurious out_valid", i), ov[i], 0);
                    else begin
                        chk($sformatf("d%0d out_data", i), od[i], sb[i][0].data);
                        chk($sformatf("d%0d latency", i), cyc - sb[i][0].acc, lat_of(i));
                    end
                end
                phs[i] = 1'b0;
                if (ov[i] && out_ready) begin
                    if (sb[i].size() > 0) begin
                        chk($sformatf("d%0d xfer data", i), od[i], sb[i][0].data);
                        void'(sb[i].pop_front());
                    end
                    xfers[i]++;
                    phs[i] = 1'b1;
                end
                pov[i] = ov[i];
                pod[i] = od[i];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d rst key", i), key[i], 0);
            chk($sformatf("d%0d rst key_ready", i), kr[i], 0);
            chk($sformatf("d%0d rst in_ready", i), ir[i], 0);
            chk($sformatf("d%0d rst core_in", i), cin[i], 0);
            chk($sformatf("d%0d rst out_valid", i), ov[i], 0);
            chk($sformatf("d%0d rst out_data", i), od[i], 0);
            chk($sformatf("d%0d rst err", i), err[i], 0);
        end
    endtask

    // Pulse key_load (with a junk strobe that must be ignored), then shift
    // nbits of v. Only a full KW-bit run commits.
    task automatic load_key(input logic [KW-1:0] v, input int nbits, input bit gaps);
        key_load = 1'b1;
        key_sval = 1'($urandom_range(0, 1));
        key_sin  = 1'($urandom_range(0, 1));
        tick();
        key_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d load start key_ready", i), kr[i], 0);
            chk($sformatf("d%0d load start key", i), key[i], cur_key);
        end
        for (int b = 0; b < nbits; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                key_sval = 1'b0;
                key_sin  = 1'($urandom_range(0, 1));
                tick();
                chk("gap key_ready", kr[0] | kr[1], 0);
            end
            key_sval = 1'b1;
            key_sin  = v[b];
            tick();
            for (int i = 0; i < 2; i++) begin
                if (b == KW - 1) begin
                    chk($sformatf("d%0d key commit", i), key[i], v);
                    chk($sformatf("d%0d key_ready commit", i), kr[i], 1);
                end else begin
                    chk($sformatf("d%0d key before commit", i), key[i], cur_key);
                    chk($sformatf("d%0d key_ready loading", i), kr[i], 0);
                end
            end
        end
        key_sval = 1'b0;
        if (nbits == KW) cur_key = v;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(ir[0] && ir[1] && sb[0].size() == 0 && sb[1].size() == 0) && k < 200) begin
            tick();
            k++;
        end
        chk("idle wait", {63'h0, ir[0] & ir[1]}, 1);
    endtask

    task automatic push_word(input logic [IW-1:0] d);
        exp_t e;
        e.data = core_fn(d);
        e.acc  = cyc + 1;
        sb[0].push_back(e);
        sb[1].push_back(e);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [IW-1:0] d);
        wait_idle();
        push_word(d);
    endtask

    task automatic wait_ov1();
        for (int k = 0; k < 40 && !ov[1]; k++) tick();
        chk("out_valid wait", ov[1], 1);
    endtask

    function automatic logic [IW-1:0] rnd_word();
        return {9'($urandom), 32'($urandom)};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int x0[2];
        int issued;
        int k;
        rst = 1'b1; key_load = 1'b0; key_sval = 1'b0; key_sin = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        check_reset();
        rst = 1'b0;

        // Traffic before any key
        in_valid = 1'b1; in_data = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("unkeyed in_ready", {63'h0, ir[0] | ir[1]}, 0);
        end
        in_valid = 1'b0;
        chk("err_unkeyed set d0", err[0], 1);
        chk("err_unkeyed set d1", err[1], 1);

        load_key(37'h1_2345_6789, KW, 1'b0);
        chk("err_unkeyed sticky d0", err[0], 1);
        chk("err_unkeyed sticky d1", err[1], 1);

        // Single transaction with the result taken at once
        out_ready = 1'b1;
        send(41'h0_DEAD_BEEF);
        chk("d0 in_ready E0", ir[0], 0);
        tick();
        chk("d0 out_valid E1", ov[0], 1);
        chk("d0 out_data E1", od[0], 32'h2152_4110);
        chk("d0 in_ready E1", ir[0], 0);
        tick();
        chk("d0 in_ready E2", ir[0], 1);
        chk("d0 out_valid E2", ov[0], 0);
        wait_idle();

        // Backpressure
        out_ready = 1'b0;
        send(rnd_word());
        wait_ov1();
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp in_ready", {63'h0, ir[0] | ir[1]}, 0);
            chk("bp out_valid", {63'h0, ov[0] & ov[1]}, 1);
        end
        x0[0] = xfers[0]; x0[1] = xfers[1];
        out_ready = 1'b1;
        repeat (4) tick();
        chk("bp single xfer d0", xfers[0] - x0[0], 1);
        chk("bp single xfer d1", xfers[1] - x0[1], 1);

        // Reload attempt during HOLD is ignored
        out_ready = 1'b0;
        send(rnd_word());
        wait_ov1();
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("hold key_load key_ready", {63'h0, kr[0] & kr[1]}, 1);
        chk("hold key_load out_valid", {63'h0, ov[0] & ov[1]}, 1);
        tick();
        out_ready = 1'b1;
        wait_idle();
        chk("after hold key_ready", {63'h0, kr[0] & kr[1]}, 1);
        chk("after hold key", key[1], 37'h1_2345_6789);

        // Partial load, restart, fresh full load
        load_key({5'($urandom), 32'($urandom)}, 20, 1'b0);
        load_key(37'h0_0000_0001, KW, 1'b0);

        // Reset in the middle of a LAT=4 wait
        out_ready = 1'b1;
        send(rnd_word());
        tick(); tick();
        chk("d1 still waiting", ov[1], 0);
        rst = 1'b1;
        tick();
        check_reset();
        cur_key = '0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("post rst out_valid", {63'h0, ov[0] | ov[1]}, 0);
        end

        // Randomized traffic with random backpressure and reloads
        load_key({5'($urandom), 32'($urandom)}, KW, 1'b1);
        issued = 0;
        k = 0;
        while (!(issued >= 40 && sb[0].size() == 0 && sb[1].size() == 0) && k < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (ir[0] && ir[1] && $urandom_range(0, 15) == 0) begin
                load_key({5'($urandom), 32'($urandom)}, KW, 1'b1);
            end else if (issued < 40 && ir[0] && ir[1] && $urandom_range(0, 1) == 1) begin
                push_word(rnd_word());
                issued++;
            end else begin
                tick();
            end
            k++;
        end
        chk("random traffic done", issued, 40);
        chk("random sb drained", sb[0].size() + sb[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/c499_lock_ctrl.md
# c499_lock_ctrl

Sequencing controller for the key-locked c499 single-error-correcting core. It serially loads the 37-bit unlock key: 33 XOR key bits X_1..X_33 in key[32:0], and 4 mux key bits p1..p4 in key[36:33]. It then admits one 41-bit data word at a time into the combinational core, waits a fixed settle latency and returns the 32-bit corrected word over a valid/ready handshake. It sits between the test/system bus and the locked core, which it drives through key and core_in.

## Interface
- KEY_W, 37, key length: bits 0..32 drive X_1..X_33, bits 33..36 drive p1..p4
- IN_W, 41, core input word width (N1..N137 order, LSB = N1)
- OUT_W, 32, core output word width (N724..N755, LSB = N724)
- LAT, 1, cycles allowed for core_out to settle after core_in changes (legal range 1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_load  in  1  start/restart serial key load
- key_sval  in  1  key_sin is valid this cycle
- key_sin  in  1  serial key bit, LSB first
- key  out  KEY_W  committed key to the locked core
- key_ready  out  1  key committed, datapath usable
- in_valid  in  1  input word offered
- in_ready  out  1  controller accepts input word
- in_data  in  IN_W  input word
- core_in  out  IN_W  registered word driven into the core
- core_out  in  OUT_W  core result (combinational)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  registered result
- err_unkeyed  out  1  sticky: in_valid seen while no key committed

## Operation
- States: UNKEYED, LOAD, KEYED, WAIT, HOLD.
- Reset values of all outputs are 0: key, key_ready, in_ready, core_in, out_valid, out_data, err_unkeyed. State is UNKEYED. Shift counter and wait counter are 0.
- UNKEYED:
  - key_load=1 moves to LOAD.
  - in_ready=0.
  - in_valid=1 sets err_unkeyed.
- LOAD:
  - Entry clears the shift counter and the shadow register.
  - Each cycle with key_sval=1 writes key_sin into shadow[cnt] and increments cnt.
  - On the KEY_W-th valid bit, the same edge copies the complete shadow (including that bit) into key, sets key_ready=1 and moves to KEYED.
  - key_load=1 in LOAD restarts the load: cnt=0, and any key_sval that cycle is ignored.
  - key keeps its previous value until the commit.
  - key_ready=0 and in_ready=0 for the whole of LOAD.
  - in_valid=1 sets err_unkeyed only if no key was ever committed.
- KEYED:
  - in_ready=1.
  - key_load=1 has priority over in_valid: it goes to LOAD, drops key_ready and accepts no word.
  - Otherwise in_valid&in_ready latches core_in<=in_data, loads the wait counter with LAT and moves to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1: out_data<=core_out, out_valid<=1, move to HOLD.
- HOLD:
  - out_valid and out_data stay stable until out_valid&out_ready.
  - On that handshake: out_valid<=0, move to KEYED.
- key_load in WAIT or HOLD is ignored; a transaction in progress is never aborted.
- core_in holds its last value outside transactions.
- err_unkeyed is cleared only by rst.
- rst mid-load or mid-transaction returns everything to reset values and discards the key.

## Timing
- Key load takes exactly KEY_W cycles with continuous key_sval. key_ready rises at the edge that samples bit KEY_W-1.
- Accept at edge E0. out_data captures core_out and out_valid rises at edge E0+LAT.
- With out_ready held high, the result is accepted at E0+LAT+1. in_ready is high again in the following cycle.
- Peak throughput is one word per LAT+2 cycles.
- in_ready is a registered state decode; there is no combinational path from in_valid or out_ready to in_ready.
- out_valid never drops without out_ready.

## Test plan
- Key load:
  - Stimulus: rst, then key_load, then shift key 37'h1_2345_6789 LSB-first over 37 consecutive cycles.
  - Required: key==37'h1_2345_6789 and key_ready=1 exactly 37 edges after the first bit; key==0 before that.
- Unkeyed traffic:
  - Stimulus: in_valid=1 with in_data=41'h0 before any key load.
  - Required: in_ready stays 0 and err_unkeyed=1; err_unkeyed still 1 after a successful key load.
- Single transaction, LAT=1:
  - Stimulus: core_out modelled as in_data[31:0]^32'hFFFF_FFFF; send in_data=41'h0_DEAD_BEEF with out_ready=1.
  - Required: out_valid high one edge after accept, out_data=32'h2152_4110, in_ready high 3 cycles after the accept cycle.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises.
  - Required: out_data stable, in_ready=0 throughout; a single transfer once out_ready=1.
- Key reload and restart:
  - Stimulus: key_load asserted during HOLD; then key_load again after 20 bits of a new load; then reload 37'h0_0000_0001.
  - Required: the first key_load is ignored; the mid-load key_load restarts the count; key becomes 1 only after 37 fresh bits.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT with LAT=4.
  - Required: all outputs 0 on the next edge, state UNKEYED, no out_valid pulse.
